rx_symbol_ber: RTL and testbench

Receive-side counterpart of the polyphase raised-cosine transmit filter.
- Accepts the 4x-oversampled filtered stream at one sample per enabled clock.
- Decimates by 4 at a programmable phase and slices each BPSK symbol by sign.
- Aligns the recovered bits against the transmitter's reference bit stream by searching the delay.
- Once locked, counts bit errors and total bits for BER measurement.

---
 rtl/rx_ber_pkg.sv | 29 ++
 rtl/rx_decimator_slicer.sv | 55 +++++
 rtl/rx_symbol_ber.sv | 177 +++++++++++++++++
 tb/tb_rx_symbol_ber.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_ber_pkg.sv
// Shared types and width helpers for the BPSK receive/BER monitor.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: FSM state encoding, oversampling ratio, and the widths
// derived from the delay range and window length.
package rx_ber_pkg;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Oversampling ratio of the incoming filtered stream.
    localparam int OS   = 4;
    localparam int PH_W = $clog2(OS);

    // The delay register indexes 0..max_delay-1.
    function automatic int dly_width(input int max_delay);
        return (max_delay > 1) ? $clog2(max_delay) : 1;
    endfunction

    // Window counters must be able to hold the value `window` itself,
    // because the search error count can reach a full window.
    function automatic int win_width(input int window);
        return $clog2(window + 1);
    endfunction

endpackage

// File: rtl/rx_decimator_slicer.sv
// Decimate-by-OS at a programmable phase and BPSK sign slicer.
// Latency: o_bit/o_bit_valid one cycle after the strobe cycle.
// Backpressure: none; i_enable=0 holds state and masks o_bit_valid.
//
// Ports: clock, i_reset (sync, active-high), i_enable, i_data (signed
// sample), i_phase (decimation phase) -> strobe and decision (same-cycle,
// for the top's alignment logic), o_bit_valid, o_bit (registered).
module rx_decimator_slicer
    import rx_ber_pkg::*;
#(
    parameter int NB_INPUT = 8
) (
    input  logic                clock,
    input  logic                i_reset,
    input  logic                i_enable,
    input  logic [NB_INPUT-1:0] i_data,
    input  logic [PH_W-1:0]     i_phase,
    output logic                strobe,
    output logic                decision,
    output logic                o_bit_valid,
    output logic                o_bit
);

    logic [PH_W-1:0] phase_cnt;
    logic            valid_q;

    // Only the sign bit matters to the slicer; magnitude bits are dropped.
    logic unused_mag;
    assign unused_mag = ^i_data[NB_INPUT-2:0];

    // A phase change is picked up by this comparison immediately.
    assign strobe   = i_enable && (phase_cnt == i_phase);
    assign decision = i_data[NB_INPUT-1];

    // valid_q follows strobe every cycle, so a pulse pending across a
    // disabled cycle is lost rather than delivered late.
    assign o_bit_valid = valid_q && i_enable;

    always_ff @(posedge clock) begin
        if (i_reset) begin
            phase_cnt <= '0;
            valid_q   <= 1'b0;
            o_bit     <= 1'b0;
        end else begin
            valid_q <= strobe;
            if (i_enable) begin
                phase_cnt <= phase_cnt + PH_W'(1);
            end
            if (strobe) begin
                o_bit <= decision;
            end
        end
    end

endmodule

// File: rtl/rx_symbol_ber.sv
// BPSK receive BER monitor: decimate, slice, search reference delay, count errors.
// Latency: o_bit one cycle after strobe; lock/counter state updates on the strobe edge.
// Backpressure: none; i_enable=0 freezes all state.
//
// Ports: clock, i_reset (sync, active-high), i_enable, i_data, i_phase,
// i_ref_bit, [i_clear] -> o_bit_valid, o_bit, o_locked, o_delay,
// o_err_count, o_bit_count.
// Optional: define RX_STATS_CLEAR_EN to add i_clear, which zeroes both
// counters on the next edge without touching lock state or delay.
module rx_symbol_ber
    import rx_ber_pkg::*;
#(
    parameter int NB_INPUT  = 8,
    parameter int MAX_DELAY = 64,
    parameter int WINDOW    = 32,
    parameter int LOSS_THR  = 4,
    parameter int NB_CNT    = 32
) (
    input  logic                         clock,
    input  logic                         i_reset,
    input  logic                         i_enable,
    input  logic [NB_INPUT-1:0]          i_data,
    input  logic [1:0]                   i_phase,
    input  logic                         i_ref_bit,
`ifdef RX_STATS_CLEAR_EN
    input  logic                         i_clear,
`endif
    output logic                         o_bit_valid,
    output logic                         o_bit,
    output logic                         o_locked,
    output logic [$clog2(MAX_DELAY)-1:0] o_delay,
    output logic [NB_CNT-1:0]            o_err_count,
    output logic [NB_CNT-1:0]            o_bit_count
);

    localparam int DLY_W = dly_width(MAX_DELAY);
    localparam int WIN_W = win_width(WINDOW);
    localparam int SR_D  = MAX_DELAY - 1;

    logic strobe;
    logic decision;
    logic ref_tap;
    logic err;

    rx_decimator_slicer #(
        .NB_INPUT (NB_INPUT)
    ) u_dec (
        .clock       (clock),
        .i_reset     (i_reset),
        .i_enable    (i_enable),
        .i_data      (i_data),
        .i_phase     (i_phase),
        .strobe      (strobe),
        .decision    (decision),
        .o_bit_valid (o_bit_valid),
        .o_bit       (o_bit)
    );

    // ---------------- reference history ----------------
    // ref_sr[k] holds the reference bit from k+1 strobes ago; delay 0
    // taps the live input so no register stage is wasted.
    logic [SR_D-1:0] ref_sr;

    always_ff @(posedge clock) begin
        if (i_reset) begin
            ref_sr <= '0;
        end else if (strobe) begin
            ref_sr <= {ref_sr[SR_D-2:0], i_ref_bit};
        end
    end

    state_t            state_q,   state_d;
    logic [DLY_W-1:0]  delay_q,   delay_d;
    logic [WIN_W-1:0]  win_cnt_q, win_cnt_d;
    logic [WIN_W-1:0]  win_err_q, win_err_d;
    logic [NB_CNT-1:0] err_cnt_q, err_cnt_d;
    logic [NB_CNT-1:0] bit_cnt_q, bit_cnt_d;
    logic              win_last;
    logic [WIN_W-1:0]  win_err_sum;

    always_comb begin
        ref_tap = i_ref_bit;
        if (delay_q != '0) begin
            ref_tap = ref_sr[delay_q - DLY_W'(1)];
        end
    end

    assign err         = decision ^ ref_tap;
    assign win_last    = (win_cnt_q == WIN_W'(WINDOW - 1));
    // Window error count including the current strobe.
    assign win_err_sum = win_err_q + WIN_W'(err);

    // ---------------- FSM and counters ----------------
    always_ff @(posedge clock) begin
        if (i_reset) begin
            state_q   <= SEARCH;
            delay_q   <= '0;
            win_cnt_q <= '0;
            win_err_q <= '0;
            err_cnt_q <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            delay_q   <= delay_d;
            win_cnt_q <= win_cnt_d;
            win_err_q <= win_err_d;
            err_cnt_q <= err_cnt_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        delay_d   = delay_q;
        win_cnt_d = win_cnt_q;
        win_err_d = win_err_q;
        err_cnt_d = err_cnt_q;
        bit_cnt_d = bit_cnt_q;

        if (strobe) begin
            case (state_q)
                SEARCH: begin
                    if (win_last) begin
                        win_cnt_d = '0;
                        win_err_d = '0;
                        if (win_err_sum == '0) begin
                            state_d = LOCKED;
                        end else begin
                            // MAX_DELAY is a power of two: overflow wraps to 0.
                            delay_d = delay_q + DLY_W'(1);
                        end
                    end else begin
                        win_cnt_d = win_cnt_q + WIN_W'(1);
                        win_err_d = win_err_sum;
                    end
                end
                LOCKED: begin
                    if (bit_cnt_q != '1) begin
                        bit_cnt_d = bit_cnt_q + NB_CNT'(1);
                    end
                    if (err && (err_cnt_q != '1)) begin
                        err_cnt_d = err_cnt_q + NB_CNT'(1);
                    end
                    if (win_err_sum >= WIN_W'(LOSS_THR)) begin
                        state_d   = SEARCH;
                        delay_d   = delay_q + DLY_W'(1);
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end else if (win_last) begin
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end else begin
                        win_cnt_d = win_cnt_q + WIN_W'(1);
                        win_err_d = win_err_sum;
                    end
                end
                default: begin
                    state_d = SEARCH;
                end
            endcase
        end

`ifdef RX_STATS_CLEAR_EN
        // Clear wins over a coincident strobe increment.
        if (i_clear) begin
            err_cnt_d = '0;
            bit_cnt_d = '0;
        end
`endif
    end

    assign o_locked    = (state_q == LOCKED);
    assign o_delay     = delay_q;
    assign o_err_count = err_cnt_q;
    assign o_bit_count = bit_cnt_q;

endmodule

// File: tb/tb_rx_symbol_ber.sv
// Randomized bench for rx_symbol_ber against a behavioural BER-monitor model.
// Latency: model predicts registered outputs one edge after each input cycle.
// Backpressure: i_enable is randomly dropped in part of the run.
module tb_rx_symbol_ber;

    localparam int NB_INPUT  = 8;
    localparam int MAX_DELAY = 64;
    localparam int WINDOW    = 32;
    localparam int LOSS_THR  = 4;
    localparam int NB_CNT    = 8;
    localparam longint CMAX  = (64'd1 << NB_CNT) - 1;

    logic                clock = 1'b0;
    logic                i_reset;
    logic                i_enable;
    logic [NB_INPUT-1:0] i_data;
    logic [1:0]          i_phase;
    logic                i_ref_bit;
`ifdef RX_STATS_CLEAR_EN
    logic                i_clear;
`endif
    logic                o_bit_valid;
    logic                o_bit;
    logic                o_locked;
    logic [5:0]          o_delay;
    logic [NB_CNT-1:0]   o_err_count;
    logic [NB_CNT-1:0]   o_bit_count;

    always #5 clock = ~clock;

    rx_symbol_ber #(
        .NB_INPUT  (NB_INPUT),
        .MAX_DELAY (MAX_DELAY),
        .WINDOW    (WINDOW),
        .LOSS_THR  (LOSS_THR),
        .NB_CNT    (NB_CNT)
    ) dut (
        .clock       (clock),
        .i_reset     (i_reset),
        .i_enable    (i_enable),
        .i_data      (i_data),
        .i_phase     (i_phase),
        .i_ref_bit   (i_ref_bit),
`ifdef RX_STATS_CLEAR_EN
        .i_clear     (i_clear),
`endif
        .o_bit_valid (o_bit_valid),
        .o_bit       (o_bit),
        .o_locked    (o_locked),
        .o_delay     (o_delay),
        .o_err_count (o_err_count),
        .o_bit_count (o_bit_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int     m_cnt = 0;       // enabled cycles modulo OS
    bit     m_pend = 0;      // a strobe happened on the previous cycle
    bit     m_bit = 0;
    bit     m_locked = 0;
    int     m_delay = 0;
    int     m_wn = 0;        // strobes seen in current window
    int     m_we = 0;        // errors seen in current window
    longint m_errc = 0;
    longint m_bitc = 0;
    bit     hist[$];         // past reference bits, most recent first

    // ---------------- stimulus knobs ----------------
    int d_tx = 0;            // how many symbols the reference leads rx
    int en_pct = 100;
    int flip_every = 0;
    int burst_left = 0;
    int sym_idx = 0;
    bit clr_pending = 0;
    bit sent[$];             // reference bits already sent, most recent first

    task automatic cycle(input bit rst);
        bit en, rbit, rx, strobe, dec, tap, err, clr;
        logic [NB_INPUT-1:0] data;
        int mag;
        en   = rst ? 1'b1 : ($urandom_range(99) < en_pct);
        rbit = 1'($urandom_range(1));
        strobe = !rst && en && (m_cnt == int'(i_phase));
        clr = 0;
        if (strobe) begin
            if (d_tx == 0) rx = rbit;
            else if (sent.size() >= d_tx) rx = sent[d_tx-1];
            else rx = 1'($urandom_range(1));
            if (burst_left > 0) begin
                rx = !rx;
                burst_left--;
            end else if (flip_every > 0 && (sym_idx % flip_every) == flip_every - 1) begin
                rx = !rx;
            end
            sym_idx++;
            if (rx) begin
                mag  = $urandom_range(128, 1);
                data = NB_INPUT'(-mag);
            end else begin
                data = NB_INPUT'($urandom_range(127, 0));
            end
            sent.push_front(rbit);
            if (sent.size() > MAX_DELAY) void'(sent.pop_back());
            clr = clr_pending;
            clr_pending = 0;
        end else begin
            data = NB_INPUT'($urandom);
        end

        i_reset   = rst;
        i_enable  = en;
        i_data    = data;
        i_ref_bit = rbit;
`ifdef RX_STATS_CLEAR_EN
        i_clear   = clr;
`endif
        #1;
        check_eq("bit_valid", o_bit_valid, m_pend && en);

        // model update for this edge
        if (rst) begin
            m_cnt = 0; m_pend = 0; m_bit = 0; m_locked = 0; m_delay = 0;
            m_wn = 0; m_we = 0; m_errc = 0; m_bitc = 0;
            hist.delete();
            sent.delete();
        end else begin
            m_pend = strobe;
            if (en) m_cnt = (m_cnt + 1) % 4;
            if (strobe) begin
                dec = ($signed(data) < 0);
                m_bit = dec;
                if (m_delay == 0) tap = rbit;
                else if (m_delay - 1 < hist.size()) tap = hist[m_delay-1];
                else tap = 0;
                err = dec ^ tap;
                m_wn++;
                m_we += int'(err);
                if (!m_locked) begin
                    if (m_wn == WINDOW) begin
                        if (m_we == 0) m_locked = 1;
                        else m_delay = (m_delay + 1) % MAX_DELAY;
                        m_wn = 0; m_we = 0;
                    end
                end else begin
                    if (m_bitc < CMAX) m_bitc++;
                    if (err && m_errc < CMAX) m_errc++;
                    if (m_we >= LOSS_THR) begin
                        m_locked = 0;
                        m_delay = (m_delay + 1) % MAX_DELAY;
                        m_wn = 0; m_we = 0;
                    end else if (m_wn == WINDOW) begin
                        m_wn = 0; m_we = 0;
                    end
                end
                hist.push_front(rbit);
                if (hist.size() > MAX_DELAY - 1) void'(hist.pop_back());
            end
            if (clr) begin
                m_errc = 0;
                m_bitc = 0;
            end
        end

        @(posedge clock);
        #1;
        check_eq("o_bit", o_bit, m_bit);
        check_eq("o_locked", o_locked, m_locked);
        check_eq("o_delay", o_delay, m_delay);
        check_eq("o_err_count", o_err_count, m_errc);
        check_eq("o_bit_count", o_bit_count, m_bitc);
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1);
    endtask

    initial begin
        int n;
        longint base_e, base_b;
        i_reset = 1'b1; i_enable = 1'b0; i_data = '0; i_phase = 2'd0; i_ref_bit = 1'b0;
`ifdef RX_STATS_CLEAR_EN
        i_clear = 1'b0;
`endif
        // ---- reset state ----
        do_reset();
        check_eq("rst_locked", o_locked, 0);
        check_eq("rst_delay", o_delay, 0);
        check_eq("rst_errc", o_err_count, 0);
        check_eq("rst_bitc", o_bit_count, 0);

        // ---- loopback at delay 0: locks on the 32nd strobe ----
        d_tx = 0; en_pct = 100; i_phase = 2'd0;
        for (int i = 0; i < 124; i++) cycle(1'b0);
        check_eq("lb_not_yet_locked", o_locked, 0);
        cycle(1'b0);
        check_eq("lb_locked", o_locked, 1);
        check_eq("lb_delay", o_delay, 0);
        for (int i = 0; i < 160; i++) cycle(1'b0);
        check_eq("lb_bitc", o_bit_count, 40);
        check_eq("lb_errc", o_err_count, 0);

        // ---- delay search: reference leads by 5 symbols ----
        do_reset();
        d_tx = 5;
        n = 0;
        while (!m_locked && n < 3000) begin cycle(1'b0); n++; end
        check_eq("srch_locked", o_locked, 1);
        check_eq("srch_delay", o_delay, 5);

        // ---- sparse error injection while locked ----
        base_e = m_errc; base_b = m_bitc;
        flip_every = 11; sym_idx = 0;
        n = 0;
        while (sym_idx < 100 && n < 2000) begin cycle(1'b0); n++; end
        check_eq("inj_errc", o_err_count, base_e + 9);
        check_eq("inj_bitc", o_bit_count, base_b + 100);
        check_eq("inj_locked", o_locked, 1);

        // ---- burst of LOSS_THR errors inside one window ----
        flip_every = 0;
        n = 0;
        while (m_wn != 0 && n < 500) begin cycle(1'b0); n++; end
        burst_left = LOSS_THR;
        n = 0;
        while (burst_left > 0 && n < 500) begin cycle(1'b0); n++; end
        check_eq("loss_locked", o_locked, 0);
        check_eq("loss_delay", o_delay, 6);

        // ---- random enable, other phase, random delay, then saturation ----
        do_reset();
        en_pct = 50; i_phase = 2'd2; d_tx = $urandom_range(10, 1);
        n = 0;
        while (!m_locked && n < 20000) begin
            if (n == 300) i_phase = 2'd1;
            cycle(1'b0);
            n++;
        end
        check_eq("gate_locked", o_locked, 1);
        check_eq("gate_delay", o_delay, d_tx);
        sym_idx = 0;
        n = 0;
        while (sym_idx < 300 && n < 10000) begin cycle(1'b0); n++; end
        check_eq("sat_bitc", o_bit_count, CMAX);
        check_eq("sat_errc", o_err_count, 0);

`ifdef RX_STATS_CLEAR_EN
        // ---- clear coincident with a strobe ----
        clr_pending = 1;
        n = 0;
        while (clr_pending && n < 200) begin cycle(1'b0); n++; end
        check_eq("clr_bitc", o_bit_count, 0);
        check_eq("clr_locked", o_locked, 1);
`endif

        // ---- reset in the middle of a window ----
        en_pct = 100;
        for (int i = 0; i < 10; i++) cycle(1'b0);
        cycle(1'b1);
        check_eq("mid_rst_locked", o_locked, 0);
        check_eq("mid_rst_delay", o_delay, 0);
        check_eq("mid_rst_bitc", o_bit_count, 0);
        check_eq("mid_rst_errc", o_err_count, 0);
        check_eq("mid_rst_bit", o_bit, 0);
        cycle(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
